// File: rtl/game_pkg.sv
`default_nettype none
// game_pkg: hit cause codes and sprite/screen geometry shared by the game core.
// bird_ctrl, pipe_gen, sprite_render and collision_engine all read these.
package game_pkg;

  localparam logic [1:0] HIT_NONE   = 2'd0;
  localparam logic [1:0] HIT_GROUND = 2'd1;
  localparam logic [1:0] HIT_CEIL   = 2'd2;
  localparam logic [1:0] HIT_PIPE   = 2'd3;

  localparam int BIRD_W     = 50;
  localparam int BIRD_H     = 35;
  localparam int PIPE_W     = 80;
  localparam int PIPE_GAP_H = 140;
  localparam int HIT_MARGIN = 5;
  localparam int GROUND_Y   = 668;
  localparam int CEIL_Y     = 0;

endpackage
`default_nettype wire

// File: rtl/aabb_pipe_test.sv
`default_nettype none
// aabb_pipe_test: combinational bird-vs-single-pipe overlap test.
// Operands are widened to signed COORD_W+2 bits so gap edges above the screen stay negative.
module aabb_pipe_test #(
  parameter int COORD_W    = 12,
  parameter int BIRD_W     = 50,
  parameter int BIRD_H     = 35,
  parameter int PIPE_W     = 80,
  parameter int PIPE_GAP_H = 140,
  parameter int HIT_MARGIN = 5
) (
  input  logic [COORD_W-1:0] bird_x,
  input  logic [COORD_W-1:0] bird_y,
  input  logic [COORD_W-1:0] pipe_x,
  input  logic [COORD_W-1:0] gap_y,
  output logic               hit
);

  localparam int SW = COORD_W + 2;

  logic signed [SW-1:0] bx, by, px, gy;
  logic signed [SW-1:0] gap_top, gap_bot;
  logic                 x_overlap, y_hit;

  assign bx = $signed({2'b00, bird_x});
  assign by = $signed({2'b00, bird_y});
  assign px = $signed({2'b00, pipe_x});
  assign gy = $signed({2'b00, gap_y});

  assign gap_top = gy - SW'(PIPE_GAP_H / 2);
  assign gap_bot = gy + SW'(PIPE_GAP_H / 2);

  // The margin shrinks the bird hitbox vertically only.
  assign x_overlap = (bx + SW'(BIRD_W) > px) && (bx < px + SW'(PIPE_W));
  assign y_hit     = (by + SW'(HIT_MARGIN) < gap_top) ||
                     (by + SW'(BIRD_H - HIT_MARGIN) > gap_bot);

  assign hit = x_overlap && y_hit;

endmodule
`default_nettype wire

// File: rtl/collision_engine.sv
`default_nettype none
// collision_engine: snapshots bird and pipes on frame_start, scans one pipe per clock,
// then resolves ground > ceiling > pipe into a sticky collision with cause and pipe index.
module collision_engine
  import game_pkg::HIT_NONE, game_pkg::HIT_GROUND, game_pkg::HIT_CEIL, game_pkg::HIT_PIPE;
#(
  parameter int NUM_PIPES  = 4,
  parameter int COORD_W    = 12,
  parameter int BIRD_W     = game_pkg::BIRD_W,
  parameter int BIRD_H     = game_pkg::BIRD_H,
  parameter int PIPE_W     = game_pkg::PIPE_W,
  parameter int PIPE_GAP_H = game_pkg::PIPE_GAP_H,
  parameter int HIT_MARGIN = game_pkg::HIT_MARGIN,
  parameter int GROUND_Y   = game_pkg::GROUND_Y,
  parameter int CEIL_Y     = game_pkg::CEIL_Y
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic                           clear_hit,
  input  logic [COORD_W-1:0]             bird_x,
  input  logic [COORD_W-1:0]             bird_y,
  input  logic [NUM_PIPES*COORD_W-1:0]   pipe_x,
  input  logic [NUM_PIPES*COORD_W-1:0]   pipe_gap_y,
  output logic                           busy,
  output logic                           check_done,
  output logic                           collision,
  output logic [1:0]                     hit_cause,
  output logic [((NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1)-1:0] hit_pipe_idx
);

  localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int SW    = COORD_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIPES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  logic [1:0]                   state;
  logic [IDX_W-1:0]             idx, first_idx;
  logic                         found;
  logic [COORD_W-1:0]           bird_x_s, bird_y_s;
  logic [NUM_PIPES*COORD_W-1:0] pipe_x_s, pipe_gap_s;

  logic [COORD_W-1:0]   cur_px, cur_gy;
  logic                 pipe_hit, ground_hit, ceil_hit;
  logic signed [SW-1:0] by_s;

  assign cur_px = pipe_x_s[idx*COORD_W +: COORD_W];
  assign cur_gy = pipe_gap_s[idx*COORD_W +: COORD_W];

  aabb_pipe_test #(
    .COORD_W    (COORD_W),
    .BIRD_W     (BIRD_W),
    .BIRD_H     (BIRD_H),
    .PIPE_W     (PIPE_W),
    .PIPE_GAP_H (PIPE_GAP_H),
    .HIT_MARGIN (HIT_MARGIN)
  ) u_aabb (
    .bird_x (bird_x_s),
    .bird_y (bird_y_s),
    .pipe_x (cur_px),
    .gap_y  (cur_gy),
    .hit    (pipe_hit)
  );

  assign by_s       = $signed({2'b00, bird_y_s});
  assign ground_hit = by_s >= SW'(GROUND_Y - BIRD_H);
  assign ceil_hit   = by_s <= SW'(CEIL_Y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      first_idx    <= '0;
      found        <= 1'b0;
      bird_x_s     <= '0;
      bird_y_s     <= '0;
      pipe_x_s     <= '0;
      pipe_gap_s   <= '0;
      busy         <= 1'b0;
      check_done   <= 1'b0;
      collision    <= 1'b0;
      hit_cause    <= HIT_NONE;
      hit_pipe_idx <= '0;
    end else begin
      check_done <= 1'b0;

      // A hit resolved in FINAL is assigned later and overrides this clear.
      if (clear_hit) begin
        collision    <= 1'b0;
        hit_cause    <= HIT_NONE;
        hit_pipe_idx <= '0;
      end

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            bird_x_s   <= bird_x;
            bird_y_s   <= bird_y;
            pipe_x_s   <= pipe_x;
            pipe_gap_s <= pipe_gap_y;
            found      <= 1'b0;
            first_idx  <= '0;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (pipe_hit && !found) begin
            found     <= 1'b1;
            first_idx <= idx;
          end
          if (idx == LAST_IDX) state <= S_FINAL;
          else                 idx   <= idx + 1'b1;
        end
        S_FINAL: begin
          if (ground_hit) begin
            collision <= 1'b1;
            hit_cause <= HIT_GROUND;
          end else if (ceil_hit) begin
            collision <= 1'b1;
            hit_cause <= HIT_CEIL;
          end else if (found) begin
            collision    <= 1'b1;
            hit_cause    <= HIT_PIPE;
            hit_pipe_idx <= first_idx;
          end
          check_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
